// File: rtl/weight_mem_loader_pkg.sv
// Shared constants, state encoding and sizing helper for the weight memory loader.
package weight_mem_loader_pkg;

    localparam int MEMORY_WIDTH_DEF = 72;
    localparam int IN_WIDTH_DEF     = 8;
    localparam int ADDRS_WIDTH_DEF  = 8;

    localparam int BEATS      = MEMORY_WIDTH_DEF / IN_WIDTH_DEF;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter width for an arbitrary beat count; never narrower than one bit.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/weight_mem_loader_word_packer.sv
// Beat counter plus assembly register: packs BEATS narrow beats into one word, LSB beat first.
module word_packer #(
    parameter int IN_WIDTH = 8,
    parameter int BEATS    = 9,
    parameter int CNT_W    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [IN_WIDTH-1:0]       data_i,
    output logic                      full_o,
    output logic [IN_WIDTH*BEATS-1:0] word_o
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IN_WIDTH*BEATS-1:0] word_q, word_d;

    assign full_o = load_i && (cnt_q == LAST_BEAT);
    // The word presented includes the beat being accepted this cycle.
    assign word_o = word_d;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
            assign word_d[gi*IN_WIDTH +: IN_WIDTH] =
                (load_i && (cnt_q == CNT_W'(gi))) ? data_i : word_q[gi*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/weight_mem_loader.sv
// Packs a narrow weight stream into memory words and writes them at consecutive addresses.
module weight_mem_loader
    import weight_mem_loader_pkg::*;
#(
    parameter int MEMORY_WIDTH = MEMORY_WIDTH_DEF,
    parameter int ADDRS_WIDTH  = ADDRS_WIDTH_DEF,
    parameter int IN_WIDTH     = IN_WIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDRS_WIDTH-1:0]  base_addrs_i,
    input  logic [ADDRS_WIDTH:0]    num_words_i,
    input  logic [IN_WIDTH-1:0]     in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [MEMORY_WIDTH-1:0] mem2_data_o,
    output logic [ADDRS_WIDTH-1:0]  wr_addrs_mem2_o,
    output logic                    wr_mem2_ld_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int NUM_BEATS = MEMORY_WIDTH / IN_WIDTH;
    localparam int CNT_W     = beat_cnt_width(NUM_BEATS);

    if ((MEMORY_WIDTH % IN_WIDTH) != 0) begin : g_bad_width
        $error("MEMORY_WIDTH must be an integer multiple of IN_WIDTH");
    end

    state_t                  state_q, state_d;
    logic [ADDRS_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDRS_WIDTH:0]    num_q, num_d;
    logic [ADDRS_WIDTH:0]    wcnt_q, wcnt_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    wr_ld_q, wr_ld_d;
    logic [MEMORY_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [ADDRS_WIDTH-1:0]  wr_addr_q, wr_addr_d;

    logic                    beat_acc;
    logic                    pk_clear;
    logic                    pk_full;
    logic [MEMORY_WIDTH-1:0] pk_word;

    // in_ready_q is only ever high in COLLECT, so this also gates acceptance by state.
    assign beat_acc = in_valid_i && in_ready_q;

    word_packer #(
        .IN_WIDTH (IN_WIDTH),
        .BEATS    (NUM_BEATS),
        .CNT_W    (CNT_W)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (pk_clear),
        .load_i  (beat_acc),
        .data_i  (in_data_i),
        .full_o  (pk_full),
        .word_o  (pk_word)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        num_d      = num_q;
        wcnt_d     = wcnt_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_ld_d    = 1'b0;
        mem_data_d = mem_data_q;
        wr_addr_d  = wr_addr_q;
        pk_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d   = base_addrs_i;
                    num_d    = num_words_i;
                    wcnt_d   = '0;
                    pk_clear = 1'b1;
                    if (num_words_i == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = COLLECT;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (pk_full) begin
                    state_d    = WRITE;
                    in_ready_d = 1'b0;
                    wr_ld_d    = 1'b1;
                    mem_data_d = pk_word;
                    wr_addr_d  = addr_q;
                end
            end
            WRITE: begin
                addr_d = addr_q + ADDRS_WIDTH'(1);
                wcnt_d = wcnt_q + (ADDRS_WIDTH+1)'(1);
                if ((wcnt_q + (ADDRS_WIDTH+1)'(1)) == num_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d    = COLLECT;
                    in_ready_d = 1'b1;
                    pk_clear   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            num_q      <= '0;
            wcnt_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ld_q    <= 1'b0;
            mem_data_q <= '0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            num_q      <= num_d;
            wcnt_q     <= wcnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ld_q    <= wr_ld_d;
            mem_data_q <= mem_data_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign wr_mem2_ld_o    = wr_ld_q;
    assign mem2_data_o     = mem_data_q;
    assign wr_addrs_mem2_o = wr_addr_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench for weight_mem_loader: directed loads, monitor checks writes and done pulses.
module tb_weight_mem_loader;
    import weight_mem_loader_pkg::*;

    localparam int MW = 72;
    localparam int AW = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addrs_i;
    logic [AW:0]   num_words_i;
    logic [IW-1:0] in_data_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [MW-1:0] mem2_data_o;
    logic [AW-1:0] wr_addrs_mem2_o;
    logic          wr_mem2_ld_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk = ~clk;

    weight_mem_loader #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW), .IN_WIDTH(IW)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .base_addrs_i    (base_addrs_i),
        .num_words_i     (num_words_i),
        .in_data_i       (in_data_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .mem2_data_o     (mem2_data_o),
        .wr_addrs_mem2_o (wr_addrs_mem2_o),
        .wr_mem2_ld_o    (wr_mem2_ld_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    typedef struct {
        bit            is_done;
        logic [AW-1:0] addr;
        logic [MW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_cycs[$];
    int   done_cycs[$];
    int   acc_cycs[$];
    int   cyc = 0;
    int   start_cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [MW-1:0] d);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write strobe or done pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_mem2_ld_o === 1'b1) begin
                strobe_cycs.push_back(cyc);
                $display("[TB] cycle %0d write addr=%02h data=%018h", cyc, wr_addrs_mem2_o, mem2_data_o);
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: got addr %0h, required no write", wr_addrs_mem2_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", MW'(wr_addrs_mem2_o), MW'(e.addr));
                    check("wr_data", mem2_data_o, e.data);
                end
                if (in_ready_o !== 1'b0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL ready_during_write: got %b, required 0", in_ready_o);
                end
            end
            if (done_o === 1'b1) begin
                done_cycs.push_back(cyc);
                $display("[TB] cycle %0d done", cyc);
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got done=1, required %0d pending writes first", exp_q.size());
                end else begin
                    void'(exp_q.pop_front());
                    check("busy_at_done", MW'(busy_o), MW'(0));
                end
            end
        end
    end

    task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] num);
        @(posedge clk); #1;
        start_i      = 1'b1;
        base_addrs_i = base;
        num_words_i  = num;
        start_cyc    = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [IW-1:0] d);
        int w = 0;
        in_data_i  = d;
        in_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_o === 1'b1) break;
            w++;
            if (w > 40) begin
                check("beat_timeout", MW'(in_ready_o), MW'(1));
                in_valid_i = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        acc_cycs.push_back(cyc);
        in_valid_i = 1'b0;
    endtask

    task automatic send_beats(input logic [IW-1:0] first, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_beat(first + IW'(i));
            if (gaps) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_drain(input int limit);
        int w = 0;
        while (exp_q.size() != 0 && w < limit) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drained", MW'(exp_q.size()), MW'(0));
    endtask

    task automatic clear_logs();
        strobe_cycs.delete();
        done_cycs.delete();
        acc_cycs.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        base_addrs_i = '0;
        num_words_i  = '0;
        in_data_i    = '0;
        in_valid_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", MW'(in_ready_o), MW'(0));
        check("rst_busy", MW'(busy_o), MW'(0));
        check("rst_done", MW'(done_o), MW'(0));
        check("rst_wr_ld", MW'(wr_mem2_ld_o), MW'(0));
        check("rst_wr_addr", MW'(wr_addrs_mem2_o), MW'(0));
        check("rst_mem_data", mem2_data_o, MW'(0));
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Basic two-word load with a continuous stream.
        clear_logs();
        push_write(8'h10, 72'h090807060504030201);
        push_write(8'h11, 72'h1211100F0E0D0C0B0A);
        push_done();
        start_load(8'h10, 9'd2);
        send_beats(8'h01, 18, 1'b0);
        wait_drain(40);
        check("basic_strobe_count", MW'(strobe_cycs.size()), MW'(2));
        if (strobe_cycs.size() >= 2 && done_cycs.size() >= 1) begin
            check("basic_first_latency", MW'(strobe_cycs[0] - start_cyc), MW'(BEATS + 1));
            check("basic_strobe_spacing", MW'(strobe_cycs[1] - strobe_cycs[0]), MW'(BEATS + 1));
            check("basic_done_after_strobe", MW'(done_cycs[0]), MW'(strobe_cycs[1] + 1));
        end
        check("basic_idle_busy", MW'(busy_o), MW'(0));

        // Same load with valid toggled every other cycle.
        clear_logs();
        push_write(8'h10, 72'h090807060504030201);
        push_write(8'h11, 72'h1211100F0E0D0C0B0A);
        push_done();
        start_load(8'h10, 9'd2);
        send_beats(8'h01, 18, 1'b1);
        wait_drain(40);
        check("gap_strobe_count", MW'(strobe_cycs.size()), MW'(2));
        if (strobe_cycs.size() >= 2 && acc_cycs.size() >= 18) begin
            check("gap_strobe0_after_9th", MW'(strobe_cycs[0]), MW'(acc_cycs[8]));
            check("gap_strobe1_after_18th", MW'(strobe_cycs[1]), MW'(acc_cycs[17]));
        end

        // Zero count: done one cycle after start, no strobe, never ready.
        clear_logs();
        push_done();
        start_load(8'h40, 9'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("zero_in_ready", MW'(in_ready_o), MW'(0));
        end
        wait_drain(10);
        check("zero_done_count", MW'(done_cycs.size()), MW'(1));
        if (done_cycs.size() >= 1)
            check("zero_done_latency", MW'(done_cycs[0] - start_cyc), MW'(1));
        check("zero_no_strobe", MW'(strobe_cycs.size()), MW'(0));

        // Address wrap from 0xFF to 0x00.
        clear_logs();
        push_write(8'hFF, 72'h292827262524232221);
        push_write(8'h00, 72'h3231302F2E2D2C2B2A);
        push_done();
        start_load(8'hFF, 9'd2);
        send_beats(8'h21, 18, 1'b0);
        wait_drain(40);
        repeat (5) @(negedge clk);
        check("wrap_done_once", MW'(done_cycs.size()), MW'(1));

        // Abort after four beats, then restart with fresh data and a stray start pulse.
        clear_logs();
        start_load(8'h30, 9'd2);
        send_beats(8'h51, 4, 1'b0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_wr_ld", MW'(wr_mem2_ld_o), MW'(0));
        check("abort_in_ready", MW'(in_ready_o), MW'(0));
        check("abort_busy", MW'(busy_o), MW'(0));
        check("abort_mem_data", mem2_data_o, MW'(0));
        rst_i = 1'b0;
        check("abort_no_write", MW'(strobe_cycs.size()), MW'(0));
        push_write(8'h20, 72'hA9A8A7A6A5A4A3A2A1);
        push_done();
        start_load(8'h20, 9'd1);
        send_beats(8'hA1, 3, 1'b0);
        start_i      = 1'b1;
        base_addrs_i = 8'h50;
        num_words_i  = 9'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        send_beats(8'hA4, 6, 1'b0);
        wait_drain(40);
        repeat (15) @(negedge clk);
        check("restart_strobe_count", MW'(strobe_cycs.size()), MW'(1));
        check("restart_idle_busy", MW'(busy_o), MW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
